pipeline_hazard_ctrl: RTL

//  Sequences the IF/ID, ID/EX and EX/MEM pipeline registers and the PC.

---
 rtl/pipe_pkg.sv | 15 +
 rtl/pipeline_hazard_ctrl_sat_counter.sv | 16 +
 rtl/pipeline_hazard_ctrl.sv | 137 +++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared opcode constants, FSM state type and enable bundle for the hazard controller.
package pipe_pkg;
    localparam logic [4:0] OP_NOP   = 5'd0;
    localparam logic [4:0] OP_LOAD  = 5'd20;
    localparam logic [4:0] OP_STORE = 5'd21;

    typedef enum logic [0:0] {RUN, MEM_WAIT} hz_state_t;

    typedef struct packed {
        logic pc;
        logic ifid;
        logic idex;
        logic exmem;
    } pipe_en_t;
endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter; sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (inc && cnt != '1)
            cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, taken-branch flushes and
// multi-cycle MEM stalls with timeout, plus stall/flush performance counters.
module pipeline_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int OP_W    = 5,
    parameter int REG_W   = 9,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_use1,
    input  logic             id_use2,
    input  logic [OP_W-1:0]  ex_opcode,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_br_taken,
    input  logic [OP_W-1:0]  mem_opcode,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    localparam int WC_W = $clog2(TIMEOUT + 1);
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(TIMEOUT - 1);

    hz_state_t       state;
    logic [WC_W-1:0] wait_cnt;
    pipe_en_t        en;
    logic            mem_is_ls, load_use, stall_inc, flush_inc;

    assign mem_is_ls = (mem_opcode == OP_W'(OP_LOAD)) || (mem_opcode == OP_W'(OP_STORE));
    assign load_use  = (ex_opcode == OP_W'(OP_LOAD)) && (ex_rd != '0) &&
                       ((id_use1 && id_rs1 == ex_rd) || (id_use2 && id_rs2 == ex_rd));

    always_comb begin
        en         = '0;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        stall_inc  = 1'b0;
        flush_inc  = 1'b0;
        if (rst) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else begin
            case (state)
                RUN: begin
                    if (mem_is_ls && !mem_ready) begin
                        stall_inc = 1'b1;
                    end else if (ex_br_taken) begin
                        en         = '1;
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                        flush_inc  = 1'b1;
                    end else if (load_use) begin
                        // Freeze PC and IF/ID, inject a bubble into ID/EX.
                        en.idex    = 1'b1;
                        en.exmem   = 1'b1;
                        idex_flush = 1'b1;
                        stall_inc  = 1'b1;
                    end else begin
                        en = '1;
                    end
                end
                MEM_WAIT: begin
                    if (mem_ready) begin
                        en = '1;
                    end else begin
                        stall_inc = 1'b1;
                        // On timeout EX/MEM overwrites the abandoned access.
                        if (wait_cnt == WC_LAST)
                            en.exmem = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RUN;
            wait_cnt <= '0;
            mem_err  <= 1'b0;
        end else begin
            mem_err <= 1'b0;
            case (state)
                RUN: begin
                    if (mem_is_ls && !mem_ready) begin
                        state    <= MEM_WAIT;
                        wait_cnt <= WC_W'(1);
                    end
                end
                MEM_WAIT: begin
                    if (mem_ready) begin
                        state    <= RUN;
                        wait_cnt <= '0;
                    end else if (wait_cnt == WC_LAST) begin
                        state    <= RUN;
                        wait_cnt <= '0;
                        mem_err  <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    assign pc_en    = en.pc;
    assign ifid_en  = en.ifid;
    assign idex_en  = en.idex;
    assign exmem_en = en.exmem;

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (stall_inc),
        .cnt (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .inc (flush_inc),
        .cnt (flush_cnt)
    );
endmodule
